binary_decoder_scan: RTL and testbench

Parametrised, registered binary-to-one-hot decoder with a built-in scan sequencer. It generalises the fixed 4-to-16 enable-gated decoder to any input width. Outputs are registered, and a self-timed scan mode walks the one-hot output across all lines at a programmable rate. It sits between the control logic and strobe/select fabrics: LED/display digit multiplexing, keypad row drive and register-bank selects.

---
 rtl/decoder_pkg.sv | 18 +
 rtl/mod_m_counter.sv | 30 +++
 rtl/binary_decoder_scan.sv | 107 ++++++++++
 tb/tb_binary_decoder_scan.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared types for the binary decoder with scan sequencer.
// Operating modes and internal sequencer states.
package decoder_pkg;

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2,
    OFF    = 2'd3
  } dec_mode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    SCANNING = 2'd2
  } dec_state_t;

endpackage

// File: rtl/mod_m_counter.sv
// Scan prescaler: counts enabled cycles and ticks at max(div,1)-1.
// A compare against >= lets a shrunken divisor fire on the next cycle.
module mod_m_counter #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] term;

  assign term = (div == '0) ? '0 : div - DIV_W'(1);
  assign tick = en && (cnt_q >= term);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/binary_decoder_scan.sv
// Registered binary-to-one-hot decoder with a self-timed scan mode.
// All outputs come straight from flops.
module binary_decoder_scan
  import decoder_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [IN_W-1:0]        binary_in,
  input  logic [DIV_W-1:0]       div,
  output logic [(1<<IN_W)-1:0]   one_hot_out,
  output logic [IN_W-1:0]        index_out,
  output logic                   valid,
  output logic                   wrap
);

  localparam int OUT_W = 1 << IN_W;

  dec_mode_t  m;
  dec_state_t state_q;
  dec_state_t state_d;

  logic [IN_W-1:0]  idx_d;
  logic             valid_d;
  logic             wrap_d;
  logic [OUT_W-1:0] oh_d;

  logic go_off;
  logic go_direct;
  logic go_load;
  logic go_run;
  logic cnt_clr;
  logic tick;

  assign m = dec_mode_t'(mode);

  assign go_off    = !en || (m == OFF);
  assign go_direct = !go_off && (m == DIRECT);
  assign go_load   = !go_off && (m == SCAN)
                     && (state_q != SCANNING);
  assign go_run    = !go_off && (m == SCAN)
                     && (state_q == SCANNING);
  assign cnt_clr   = go_off || go_direct || go_load;

  mod_m_counter #(
    .DIV_W(DIV_W)
  ) u_presc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (cnt_clr),
    .en     (go_run),
    .div    (div),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = index_out;
    valid_d = valid;
    wrap_d  = 1'b0;
    unique case (1'b1)
      go_off: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      go_direct: begin
        state_d = ACTIVE;
        idx_d   = binary_in;
        valid_d = 1'b1;
      end
      go_load: begin
        state_d = SCANNING;
        idx_d   = binary_in;
        valid_d = 1'b1;
      end
      go_run: begin
        if (tick) begin
          idx_d  = index_out + 1'b1;
          wrap_d = &index_out;
        end
      end
      default: ;
    endcase
    oh_d = valid_d ? (OUT_W'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      index_out   <= '0;
      valid       <= 1'b0;
      wrap        <= 1'b0;
      one_hot_out <= '0;
    end else begin
      state_q     <= state_d;
      index_out   <= idx_d;
      valid       <= valid_d;
      wrap        <= wrap_d;
      one_hot_out <= oh_d;
    end
  end

endmodule

// File: tb/tb_binary_decoder_scan.sv
// Bench for binary_decoder_scan: four widths driven in parallel,
// checked against a cycle model plus directed literal expectations.
module tb_binary_decoder_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd3;
  logic [5:0]  bin = '0;
  logic [15:0] div = 16'd1;

  logic [3:0]  oh2;
  logic [1:0]  ix2;
  logic        v2, w2;
  logic [7:0]  oh3;
  logic [2:0]  ix3;
  logic        v3, w3;
  logic [15:0] oh4;
  logic [3:0]  ix4;
  logic        v4, w4;
  logic [63:0] oh6;
  logic [5:0]  ix6;
  logic        v6, w6;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  binary_decoder_scan #(.IN_W(2), .DIV_W(16)) u2 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .binary_in(bin[1:0]), .div(div), .one_hot_out(oh2),
    .index_out(ix2), .valid(v2), .wrap(w2));
  binary_decoder_scan #(.IN_W(3), .DIV_W(16)) u3 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .binary_in(bin[2:0]), .div(div), .one_hot_out(oh3),
    .index_out(ix3), .valid(v3), .wrap(w3));
  binary_decoder_scan #(.IN_W(4), .DIV_W(16)) u4 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .binary_in(bin[3:0]), .div(div), .one_hot_out(oh4),
    .index_out(ix4), .valid(v4), .wrap(w4));
  binary_decoder_scan #(.IN_W(6), .DIV_W(16)) u6 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode),
    .binary_in(bin), .div(div), .one_hot_out(oh6),
    .index_out(ix6), .valid(v6), .wrap(w6));

  logic [63:0] a_oh[4];
  logic [5:0]  a_ix[4];
  logic        a_v[4];
  logic        a_w[4];

  assign a_oh[0] = {60'b0, oh2};
  assign a_oh[1] = {56'b0, oh3};
  assign a_oh[2] = {48'b0, oh4};
  assign a_oh[3] = oh6;
  assign a_ix[0] = {4'b0, ix2};
  assign a_ix[1] = {3'b0, ix3};
  assign a_ix[2] = {2'b0, ix4};
  assign a_ix[3] = ix6;
  assign a_v[0] = v2;
  assign a_v[1] = v3;
  assign a_v[2] = v4;
  assign a_v[3] = v6;
  assign a_w[0] = w2;
  assign a_w[1] = w3;
  assign a_w[2] = w4;
  assign a_w[3] = w6;

  // Model: index held for `period` cycles, then advances mod lines.
  int nlines[4] = '{4, 8, 16, 64};
  int m_idx[4];
  int m_held[4];
  int m_st[4];
  bit m_val[4];
  bit m_wrap[4];

  always @(posedge clk or negedge reset_n) begin
    int period;
    period = (div == 16'd0) ? 1 : int'(div);
    for (int k = 0; k < 4; k++) begin
      if (!reset_n) begin
        m_idx[k] = 0; m_held[k] = 0; m_st[k] = 0;
        m_val[k] = 0; m_wrap[k] = 0;
      end else if (!en || mode == 2'd3) begin
        m_st[k] = 0; m_val[k] = 0; m_held[k] = 0; m_wrap[k] = 0;
      end else if (mode == 2'd0) begin
        m_st[k] = 1; m_idx[k] = int'(bin) % nlines[k];
        m_val[k] = 1; m_wrap[k] = 0;
      end else if (mode == 2'd1) begin
        m_wrap[k] = 0;
        if (m_st[k] != 2) begin
          m_st[k] = 2; m_idx[k] = int'(bin) % nlines[k];
          m_val[k] = 1; m_held[k] = 0;
        end else begin
          m_held[k] = m_held[k] + 1;
          if (m_held[k] >= period) begin
            m_held[k] = 0;
            m_wrap[k] = (m_idx[k] == nlines[k] - 1);
            m_idx[k] = (m_idx[k] + 1) % nlines[k];
          end
        end
      end else begin
        m_wrap[k] = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        logic [63:0] e;
        e = m_val[k] ? (64'd1 << m_idx[k]) : 64'd0;
        chk($sformatf("model_oh%0d", k), a_oh[k], e);
        chk($sformatf("model_ix%0d", k), 64'(a_ix[k]), 64'(m_idx[k]));
        chk($sformatf("model_v%0d", k), 64'(a_v[k]), 64'(m_val[k]));
        chk($sformatf("model_w%0d", k), 64'(a_w[k]), 64'(m_wrap[k]));
      end
    end
  end

  task automatic ck();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int seq[12] = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1, 1, 1};
    int wc;
    int wc2;
    ck();
    ck();
    chk_en = 1;
    chk("rst_oh", 64'(oh4), 64'd0);
    chk("rst_ix", 64'(ix4), 64'd0);
    chk("rst_v", 64'(v4), 64'd0);
    chk("rst_w", 64'(w4), 64'd0);

    reset_n = 1; en = 1; mode = 2'd1; div = 16'd1; bin = 6'd0;
    repeat (5) ck();
    chk("pre_rst_ix", 64'(ix4), 64'd4);
    #2;
    reset_n = 0;
    #1;
    chk("arst_oh", 64'(oh4), 64'd0);
    chk("arst_ix", 64'(ix4), 64'd0);
    chk("arst_v", 64'(v4), 64'd0);
    ck();
    reset_n = 1; mode = 2'd0; bin = 6'd5;
    ck();
    chk("post_rst_oh", 64'(oh4), 64'h0020);
    chk("post_rst_v", 64'(v4), 64'd1);

    for (int i = 0; i < 64; i++) begin
      bin = 6'(i);
      ck();
      if (i < 16) chk("direct_oh4", 64'(oh4), 64'd1 << i);
      chk("direct_ix6", 64'(ix6), 64'(i));
    end
    en = 0;
    ck();
    chk("en0_oh", 64'(oh4), 64'd0);
    chk("en0_v", 64'(v4), 64'd0);
    chk("en0_ix_kept", 64'(ix4), 64'd15);

    en = 1; mode = 2'd1; div = 16'd3; bin = 6'd6;
    for (int c = 0; c < 12; c++) begin
      ck();
      chk("scan3_ix", 64'(ix3), 64'(seq[c]));
      chk("scan3_wrap", 64'(w3), (c == 6) ? 64'd1 : 64'd0);
    end

    div = 16'd0;
    wc = 0;
    repeat (16) begin
      ck();
      wc += int'(w3);
    end
    chk("div0_wraps", 64'(wc), 64'd2);
    div = 16'd1;
    wc = 0;
    repeat (16) begin
      ck();
      wc += int'(w3);
    end
    chk("div1_wraps", 64'(wc), 64'd2);

    mode = 2'd0; bin = 6'd0;
    ck();
    mode = 2'd1; div = 16'd10;
    ck();
    chk("div10_entry", 64'(ix3), 64'd0);
    repeat (5) ck();
    chk("div10_cnt5", 64'(ix3), 64'd0);
    div = 16'd2;
    ck(); chk("divchg_step", 64'(ix3), 64'd1);
    ck(); chk("div2_a", 64'(ix3), 64'd1);
    ck(); chk("div2_b", 64'(ix3), 64'd2);
    ck(); chk("div2_c", 64'(ix3), 64'd2);
    ck(); chk("div2_d", 64'(ix3), 64'd3);
    ck(); chk("div2_e", 64'(ix3), 64'd3);

    mode = 2'd2; bin = 6'd7;
    repeat (7) begin
      ck();
      chk("hold_ix", 64'(ix3), 64'd3);
      chk("hold_oh", 64'(oh3), 64'h08);
      chk("hold_w", 64'(w3), 64'd0);
    end
    mode = 2'd1;
    ck();
    chk("hold_resume", 64'(ix3), 64'd4);

    mode = 2'd0; bin = 6'd0;
    ck();
    mode = 2'd1; div = 16'd1;
    ck();
    chk("sweep_entry", 64'(ix6), 64'd0);
    wc = 0;
    wc2 = 0;
    repeat (64) begin
      ck();
      wc += int'(w6);
      wc2 += int'(w2);
    end
    chk("sweep_ix6", 64'(ix6), 64'd0);
    chk("sweep_wraps6", 64'(wc), 64'd1);
    chk("sweep_wraps2", 64'(wc2), 64'd16);

    mode = 2'd3;
    ck();
    chk("off_v", 64'(v6), 64'd0);
    chk("off_oh", oh6, 64'd0);
    ck();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
